// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - request/result bundle between the execute stage and the mul/div unit
//
// Signals:
//   i_Start   request, capture operands/function this cycle
//   i_Func    operation select (MUL, MULH, MULHU, DIV, DIVU, REM, REMU, reserved)
//   i_Op1     multiplicand / dividend
//   i_Op2     multiplier / divisor
//   i_Flush   abort the in-flight operation
//   o_Busy    stall request while iterating
//   o_Valid   one-cycle pulse, o_Result holds a new result
//   o_Result  result, held until the next o_Valid
// Modports: master = execute stage (drives requests), slave = mul/div unit.

interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             i_Start;
    logic [2:0]       i_Func;
    logic [WIDTH-1:0] i_Op1;
    logic [WIDTH-1:0] i_Op2;
    logic             i_Flush;
    logic             o_Busy;
    logic             o_Valid;
    logic [WIDTH-1:0] o_Result;

    modport master (
        output i_Start, i_Func, i_Op1, i_Op2, i_Flush,
        input  o_Busy, o_Valid, o_Result
    );

    modport slave (
        input  i_Start, i_Func, i_Op1, i_Op2, i_Flush,
        output o_Busy, o_Valid, o_Result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative one-bit-per-cycle multiply/divide unit for the execute stage
//
// Ports:
//   i_Clk   clock, all state updates on the rising edge
//   i_Rst   synchronous active-high reset
//   bus     ex_muldiv_unit_if.slave: i_Start/i_Func/i_Op1/i_Op2/i_Flush in,
//           o_Busy/o_Valid/o_Result out (all outputs registered)
// Fixed latency of WIDTH+1 cycles from the accepted start to the o_Valid pulse,
// for every function including divide-by-zero, overflow and the reserved code.

module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    ex_muldiv_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    localparam logic [2:0] F_MUL   = 3'b000;
    localparam logic [2:0] F_MULH  = 3'b001;
    localparam logic [2:0] F_MULHU = 3'b010;
    localparam logic [2:0] F_DIV   = 3'b011;
    localparam logic [2:0] F_DIVU  = 3'b100;
    localparam logic [2:0] F_REM   = 3'b101;
    localparam logic [2:0] F_REMU  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       func_q;
    logic [CW-1:0]    cnt;
    // Multiply: acc_hi:acc_lo is the running product, acc_lo starts as the multiplier.
    // Divide:   acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;          // multiplicand or divisor
    logic             neg_q;        // negate product / quotient at the end
    logic             neg_r;        // negate remainder at the end (dividend sign)
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    logic is_signed_func;
    logic is_mul_func;
    assign is_signed_func = (bus.i_Func == F_MULH) || (bus.i_Func == F_DIV) || (bus.i_Func == F_REM);
    assign is_mul_func    = (func_q == F_MUL) || (func_q == F_MULH) || (func_q == F_MULHU);

    // One shift-add multiply step and one restoring divide step.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH:0]   div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb});
        div_diff  = div_shift - {1'b0, opb};
    end

    // Final result selection. The high half of a negated 2*WIDTH product is
    // ~hi plus the carry out of ~lo+1, which only happens when lo is zero.
    logic [WIDTH-1:0] mulh_signed;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] remv;
    logic [WIDTH-1:0] final_res;

    always_comb begin
        mulh_signed = neg_q ? (~acc_hi + {{(WIDTH-1){1'b0}}, (acc_lo == '0)}) : acc_hi;
        quot        = neg_q ? -acc_lo : acc_lo;
        remv        = neg_r ? -acc_hi : acc_hi;
        final_res   = '0;
        case (func_q)
            F_MUL:         final_res = acc_lo;
            F_MULH:        final_res = mulh_signed;
            F_MULHU:       final_res = acc_hi;
            // A zero divisor leaves an all-ones quotient, but the signed
            // negation would spoil it, so force it explicitly.
            F_DIV, F_DIVU: final_res = (opb == '0) ? '1 : quot;
            F_REM, F_REMU: final_res = remv;
            default:       final_res = '0;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= S_IDLE;
            func_q   <= '0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (bus.i_Flush) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    valid_q <= 1'b0;
                    if (bus.i_Start) begin
                        func_q <= bus.i_Func;
                        cnt    <= '0;
                        acc_hi <= '0;
                        state  <= S_CALC;
                        busy_q <= 1'b1;
                        if (bus.i_Func == F_MUL || bus.i_Func == F_MULH || bus.i_Func == F_MULHU) begin
                            opb    <= is_signed_func ? mag(bus.i_Op1) : bus.i_Op1;
                            acc_lo <= is_signed_func ? mag(bus.i_Op2) : bus.i_Op2;
                        end else begin
                            opb    <= is_signed_func ? mag(bus.i_Op2) : bus.i_Op2;
                            acc_lo <= is_signed_func ? mag(bus.i_Op1) : bus.i_Op1;
                        end
                        neg_q <= is_signed_func && (bus.i_Op1[WIDTH-1] ^ bus.i_Op2[WIDTH-1]);
                        neg_r <= is_signed_func && bus.i_Op1[WIDTH-1];
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    valid_q <= 1'b0;
                    if (cnt == LAST) begin
                        result_q <= final_res;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (is_mul_func) begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end else begin
                            acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Busy   = busy_q;
    assign bus.o_Valid  = valid_q;
    assign bus.o_Result = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit

module tb_ex_muldiv_unit;
    localparam int W = 32;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    ex_muldiv_unit_if #(.WIDTH(W)) mif ();

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        up = {32'b0, a} * {32'b0, b};
        case (f)
            3'd0: return up[31:0];
            3'd1: return sp[63:32];
            3'd2: return up[63:32];
            3'd3: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd5: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            3'd6: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Transaction-level model: an accepted start yields its result LAT cycles later.
    logic        m_busy = 1'b0, m_valid = 1'b0, m_active = 1'b0;
    logic [31:0] m_result = '0, m_pend = '0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_result <= '0; m_active <= 1'b0; m_left <= 0;
        end else if (mif.i_Flush) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_active <= 1'b0;
        end else if (m_active) begin
            if (m_left == 1) begin
                m_valid <= 1'b1; m_result <= m_pend; m_active <= 1'b0; m_busy <= 1'b0;
            end else begin
                m_valid <= 1'b0; m_left <= m_left - 1;
            end
        end else begin
            m_valid <= 1'b0;
            if (mif.i_Start) begin
                m_active <= 1'b1; m_busy <= 1'b1; m_left <= LAT;
                m_pend   <= ref_calc(mif.i_Func, mif.i_Op1, mif.i_Op2);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'b0, mif.o_Busy}, {31'b0, m_busy});
        chk("valid", {31'b0, mif.o_Valid}, {31'b0, m_valid});
        chk("result", mif.o_Result, m_result);
    end

    // Call just after a negedge; returns at the negedge after the start edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output int t0);
        mif.i_Start = 1'b1; mif.i_Func = f; mif.i_Op1 = a; mif.i_Op2 = b;
        @(posedge clk);
        @(negedge clk);
        mif.i_Start = 1'b0;
        mif.i_Op1 = $urandom;
        mif.i_Op2 = $urandom;
        t0 = cyc;
    endtask

    task automatic wait_valid(input int t0, input logic [31:0] lit, input string name);
        int n = 0;
        while (!mif.o_Valid && n < LAT + 8) begin
            @(negedge clk);
            n++;
        end
        if (!mif.o_Valid) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout actual=no_valid required=valid_after_%0d", name, LAT);
        end else begin
            chk(name, mif.o_Result, lit);
            chk({name, "_latency"}, cyc - t0, LAT);
        end
    endtask

    task automatic count_valids(input int ncyc, output int nv);
        nv = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (mif.o_Valid) nv++;
        end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lit;
        string       name;
    } vec_t;

    vec_t vecs[10] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"},
        '{3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, "mulh_7_m3"},
        '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"},
        '{3'd3, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2"},
        '{3'd5, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2"},
        '{3'd4, 32'd100,        32'd7,         32'd14,        "divu_100_7"},
        '{3'd6, 32'd100,        32'd7,         32'd2,         "remu_100_7"},
        '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "divu_by0"},
        '{3'd5, 32'd5,          32'd0,         32'd5,         "rem_by0"},
        '{3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"}
    };

    initial begin
        int t0, t1, nv;
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, nv;
        mif.i_Start = 1'b1; mif.i_Func = 3'd0; mif.i_Op1 = 32'd7; mif.i_Op2 = 32'd3; mif.i_Flush = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_busy", {31'b0, mif.o_Busy}, 32'd0);
            chk("rst_valid", {31'b0, mif.o_Valid}, 32'd0);
            chk("rst_result", mif.o_Result, 32'd0);
        end
        rst = 1'b0;
        mif.i_Start = 1'b0;
        @(negedge clk);

        chk("model_mul", ref_calc(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("model_div", ref_calc(3'd3, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model_rem_ovf", ref_calc(3'd5, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
        chk("model_reserved", ref_calc(3'd7, 32'd9, 32'd9), 32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b, t0);
            wait_valid(t0, vecs[i].lit, vecs[i].name);
            @(negedge clk);
        end

        issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, t0);
        wait_valid(t0, 32'd0, "rem_ovf");
        @(negedge clk);
        issue(3'd7, 32'd9, 32'd9, t0);
        wait_valid(t0, 32'd0, "reserved");
        @(negedge clk);

        // Start while calculating is ignored; operands were captured at acceptance.
        issue(3'd4, 32'd100, 32'd7, t0);
        repeat (4) @(negedge clk);
        mif.i_Start = 1'b1; mif.i_Func = 3'd0; mif.i_Op1 = 32'd2; mif.i_Op2 = 32'd2;
        @(negedge clk);
        mif.i_Start = 1'b0;
        wait_valid(t0, 32'd14, "start_in_calc");
        @(negedge clk);

        // Back-to-back: restart in the DONE cycle.
        issue(3'd0, 32'd3, 32'd4, t0);
        wait_valid(t0, 32'd12, "b2b_first");
        chk("b2b_busy_gap", {31'b0, mif.o_Busy}, 32'd0);
        issue(3'd0, 32'd5, 32'd6, t1);
        chk("b2b_busy_again", {31'b0, mif.o_Busy}, 32'd1);
        chk("b2b_start_gap", t1 - t0, LAT + 1);
        wait_valid(t1, 32'd30, "b2b_second");
        @(negedge clk);

        // Flush at cycle 10 of DIVU.
        issue(3'd4, 32'd1000, 32'd3, t0);
        repeat (9) @(negedge clk);
        mif.i_Flush = 1'b1;
        @(negedge clk);
        mif.i_Flush = 1'b0;
        chk("flush_busy", {31'b0, mif.o_Busy}, 32'd0);
        count_valids(LAT + 8, nv);
        chk("flush_no_valid", nv, 32'd0);
        chk("flush_result_kept", mif.o_Result, 32'd30);

        // Flush together with start: start ignored.
        mif.i_Start = 1'b1; mif.i_Flush = 1'b1; mif.i_Func = 3'd0; mif.i_Op1 = 32'd2; mif.i_Op2 = 32'd2;
        @(negedge clk);
        mif.i_Start = 1'b0; mif.i_Flush = 1'b0;
        chk("flush_start_busy", {31'b0, mif.o_Busy}, 32'd0);
        count_valids(LAT + 4, nv);
        chk("flush_start_no_valid", nv, 32'd0);

        // Reset mid-operation.
        issue(3'd4, 32'd1000, 32'd3, t0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'b0, mif.o_Busy}, 32'd0);
        chk("midrst_result", mif.o_Result, 32'd0);
        count_valids(LAT + 8, nv);
        chk("midrst_no_valid", nv, 32'd0);

        issue(3'd6, 32'd1000, 32'd3, t0);
        wait_valid(t0, 32'd1, "after_rst_remu");
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
